// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, oversampling constants and
// the baud divider calculation used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] SAMPLE_LO  = 4'd7;
  localparam logic [3:0] SAMPLE_MID = 4'd8;
  localparam logic [3:0] SAMPLE_HI  = 4'd9;
  localparam logic [3:0] SUB_LAST   = 4'(OVERSAMPLE - 1);

  // Clocks per oversample tick; integer division truncates toward zero.
  function automatic int calc_bps_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running modulo-bps_div counter that can be
// held at zero so the tick phase lines up with a detected start edge.
module uart_baud_tick #(
  parameter int bps_div = 27
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (bps_div > 1) ? $clog2(bps_div) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(bps_div - 1);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;

  assign tick = (div_cnt_q == CNT_LAST);

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (clr || tick) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority per bit,
// false-start rejection and framing-error reporting.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int clk_freq = 50000000,
  parameter int baud     = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int BPS_DIV = calc_bps_div(clk_freq, baud);

  logic       rx_meta_q, rx_s_q, rx_prev_q;
  rx_state_e  state_q, state_d;
  logic [3:0] sub_cnt_q, sub_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [1:0] samp_q, samp_d;
  logic [7:0] data_q, data_d;
  logic       rx_done_q, rx_done_d;
  logic       frame_err_q, frame_err_d;
  logic       rx_busy_q, rx_busy_d;
  logic       tick, fall, maj;

  // Divider is held cleared while idle, so the first tick lands bps_div
  // clocks after START is entered.
  uart_baud_tick #(
    .bps_div(BPS_DIV)
  ) u_baud_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (state_q == IDLE),
    .tick   (tick)
  );

  assign fall = !rx_s_q && rx_prev_q;
  // Samples 7 and 8 are stored; the current line value serves as sample 9.
  assign maj  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

  always_comb begin
    state_d     = state_q;
    sub_cnt_d   = sub_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    samp_d      = samp_q;
    data_d      = data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    if (state_q == IDLE) begin
      sub_cnt_d = '0;
      bit_cnt_d = '0;
      if (fall) begin
        state_d = START;
      end
    end else if (tick) begin
      sub_cnt_d = sub_cnt_q + 4'd1;
      if (sub_cnt_q == SAMPLE_LO)  samp_d[0] = rx_s_q;
      if (sub_cnt_q == SAMPLE_MID) samp_d[1] = rx_s_q;
      if (sub_cnt_q == SUB_LAST)   bit_cnt_d = bit_cnt_q + 3'd1;

      unique case (state_q)
        START: begin
          if (sub_cnt_q == SAMPLE_HI && maj) begin
            state_d = IDLE;
          end else if (sub_cnt_q == SUB_LAST) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          if (sub_cnt_q == SAMPLE_HI) begin
            shift_d = {maj, shift_q[7:1]};
          end
          if (sub_cnt_q == SUB_LAST && bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end
        end
        STOP: begin
          // Leave mid stop bit so the rest of it is available for resync.
          if (sub_cnt_q == SAMPLE_HI) begin
            state_d = IDLE;
            if (maj) begin
              data_d    = shift_q;
              rx_done_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    rx_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= IDLE;
      sub_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      data_q      <= 8'h00;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      rx_meta_q   <= uart_rx;
      rx_s_q      <= rx_meta_q;
      rx_prev_q   <= rx_s_q;
      state_q     <= state_d;
      sub_cnt_q   <= sub_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      rx_busy_q   <= rx_busy_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    samp_q  <= samp_d;
  end

  assign data      = data_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: bit-level line driver, expected-event scoreboard,
// table of frames plus hand-written glitch, framing-error and reset sequences.
module tb_uart_byte_rx;

  localparam int BIT_CLKS = 434;
  localparam int LAT_EXP  = 4158;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       uart_rx;
  logic [7:0] data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  uart_byte_rx dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .uart_rx  (uart_rx),
    .data     (data),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] byte_val;
    bit         chk_lat;
  } exp_t;

  typedef struct {
    logic [7:0] tx_byte;
    int         period;
    bit         stop_bit;
    int         idle_after;
    bit         exp_done;
    logic [7:0] exp_data;
    bit         chk_lat;
  } vec_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         n_pulses = 0;
  int         cyc = 0;
  int         busy_rise_cyc = 0;
  bit         busy_prev = 1'b0;
  bit         busy_seen = 1'b0;
  logic [7:0] last_data = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: every rx_done/frame_err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset_n) begin
      last_data = 8'h00;
    end else begin
      if (rx_busy && !busy_prev) busy_rise_cyc = cyc;
      if (rx_busy) busy_seen = 1'b1;
      if (rx_done || frame_err) begin
        exp_t e;
        n_pulses++;
        check("done_err_exclusive", int'(rx_done && frame_err), 0);
        check("busy_low_at_pulse", int'(rx_busy), 0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got rx_done=%0b frame_err=%0b expected none",
                   rx_done, frame_err);
        end else begin
          e = sb.pop_front();
          check("pulse_kind_frame_err", int'(frame_err), int'(e.is_err));
          if (rx_done && !e.is_err) check("rx_data", int'(data), int'(e.byte_val));
          if (e.chk_lat) begin
            checks++;
            if ((cyc - busy_rise_cyc) < LAT_EXP - 3 || (cyc - busy_rise_cyc) > LAT_EXP + 3) begin
              errors++;
              $display("FAIL latency: got %0d expected %0d+-3", cyc - busy_rise_cyc, LAT_EXP);
            end
          end
        end
        if (rx_done) last_data = data;
      end else begin
        check("data_hold", int'(data), int'(last_data));
      end
    end
    busy_prev = rx_busy;
    cyc++;
  end

  task automatic line_idle(input int nclk);
    for (int i = 0; i < nclk; i++) begin
      @(negedge clk);
      uart_rx = 1'b1;
    end
  endtask

  // Drives up to max_clks clocks of a frame; clock glitch_at (if >= 0) is inverted.
  task automatic send_frame(input logic [7:0] b, input int period, input bit stop,
                            input int glitch_at, input int max_clks);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int c = 0; c < 10 * period && c < max_clks; c++) begin
      @(negedge clk);
      uart_rx = (c == glitch_at) ? ~bits[c / period] : bits[c / period];
    end
  endtask

  task automatic expect_byte(input logic [7:0] b, input bit lat);
    exp_t e;
    e.is_err   = 1'b0;
    e.byte_val = b;
    e.chk_lat  = lat;
    sb.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err   = 1'b1;
    e.byte_val = 8'h00;
    e.chk_lat  = 1'b0;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vec[5];
    int   p0;
    vec[0] = '{8'h55, BIT_CLKS, 1'b1, 868, 1'b1, 8'h55, 1'b1};
    vec[1] = '{8'hA3, BIT_CLKS, 1'b1, 0,   1'b1, 8'hA3, 1'b0};
    vec[2] = '{8'h0F, BIT_CLKS, 1'b1, 868, 1'b1, 8'h0F, 1'b0};
    vec[3] = '{8'hC6, 447,      1'b1, 868, 1'b1, 8'hC6, 1'b0};
    vec[4] = '{8'hC6, 421,      1'b1, 868, 1'b1, 8'hC6, 1'b0};

    reset_n = 1'b0;
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_data", int'(data), 8'h00);
    check("reset_rx_done", int'(rx_done), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_rx_busy", int'(rx_busy), 0);
    reset_n = 1'b1;
    line_idle(10000);
    check("quiet_after_reset_pulses", n_pulses, 0);

    for (int i = 0; i < 5; i++) begin
      if (vec[i].exp_done) expect_byte(vec[i].exp_data, vec[i].chk_lat);
      else expect_err();
      send_frame(vec[i].tx_byte, vec[i].period, vec[i].stop_bit, -1, 10 * vec[i].period);
      line_idle(vec[i].idle_after);
    end
    drain(5000);

    // Short low pulse must abort as a false start.
    busy_seen = 1'b0;
    p0 = n_pulses;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      uart_rx = 1'b0;
    end
    line_idle(1000);
    check("glitch_busy_seen", int'(busy_seen), 1);
    check("glitch_busy_cleared", int'(rx_busy), 0);
    check("glitch_no_pulses", n_pulses, p0);
    expect_byte(8'h3C, 1'b0);
    send_frame(8'h3C, BIT_CLKS, 1'b1, -1, 10 * BIT_CLKS);
    line_idle(868);
    drain(5000);

    // One inverted clock lands on the middle sample of data bit 2.
    expect_byte(8'h3C, 1'b0);
    send_frame(8'h3C, BIT_CLKS, 1'b1, 1539, 10 * BIT_CLKS);
    line_idle(868);
    drain(5000);

    // Stop bit low followed by a break: one frame_err, data holds 0x3C.
    p0 = n_pulses;
    expect_err();
    send_frame(8'hFF, BIT_CLKS, 1'b0, -1, 10 * BIT_CLKS);
    for (int i = 0; i < 5 * BIT_CLKS; i++) begin
      @(negedge clk);
      uart_rx = 1'b0;
    end
    drain(100);
    check("break_single_pulse", n_pulses - p0, 1);
    check("break_data_held", int'(data), 8'h3C);
    line_idle(868);
    expect_byte(8'h81, 1'b0);
    send_frame(8'h81, BIT_CLKS, 1'b1, -1, 10 * BIT_CLKS);
    line_idle(868);
    drain(5000);

    // Reset in the middle of data bit 4.
    send_frame(8'h5A, BIT_CLKS, 1'b1, -1, 5 * BIT_CLKS + 217);
    @(negedge clk);
    reset_n = 1'b0;
    uart_rx = 1'b1;
    #1;
    check("midreset_data", int'(data), 8'h00);
    check("midreset_rx_done", int'(rx_done), 0);
    check("midreset_frame_err", int'(frame_err), 0);
    check("midreset_rx_busy", int'(rx_busy), 0);
    repeat (20) @(negedge clk);
    reset_n = 1'b1;
    line_idle(868);
    expect_byte(8'h81, 1'b0);
    send_frame(8'h81, BIT_CLKS, 1'b1, -1, 10 * BIT_CLKS);
    line_idle(868);
    drain(5000);
    check("final_data", int'(data), 8'h81);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

Receive-side counterpart of `uart_byte_tx`. It recovers 8N1 asynchronous serial bytes from the `uart_rx` pin and presents each byte with a one-cycle `rx_done` strobe. The receiver uses 16x oversampling, takes a 3-sample majority vote per bit, rejects false starts and flags framing errors. It sits between the board UART pin and any byte consumer, such as a loopback or command parser driving `uart_byte_tx`.

## Interface
Parameters:
- `clk_freq`, default 50000000: system clock frequency in Hz.
- `baud`, default 115200: line rate. Overridden per instance via defparam.

Ports:
- `clk`  input  1: single system clock; all logic on its rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `uart_rx`  input  1: serial line, idle high, asynchronous to `clk`.
- `data`  output  8: last correctly framed byte; holds until the next good byte.
- `rx_done`  output  1: one-clock pulse when `data` is updated.
- `frame_err`  output  1: one-clock pulse when the stop bit samples low.
- `rx_busy`  output  1: high whenever the FSM is not in IDLE.

## Operation
- **Input synchroniser:** two-flop synchroniser on `uart_rx`, both flops reset to 1. All logic uses the synchronised value `rx_s`. A falling edge is `rx_s`=0 with the previous `rx_s`=1.
- **Oversample tick:** `bps_div` = clk_freq/(baud*16), integer division (27 at the defaults). `div_cnt` counts 0..bps_div-1. `tick` is asserted when `div_cnt`==bps_div-1.
  - `div_cnt` clears on entering START, so ticks are aligned to the detected edge.
- **Sub-bit counter:** `sub_cnt` (4 bit) advances on each tick and wraps 15→0. On each wrap `bit_cnt` increments.
- **Sampling:** `rx_s` is sampled on the ticks where `sub_cnt` = 7, 8 and 9. Bit value = majority of the 3 samples.
- **FSM:**
  - IDLE → START on a falling edge.
  - START: if the majority is 1 at the `sub_cnt`=9 tick, it is a false start → IDLE. Otherwise → DATA at the `sub_cnt`=15 tick.
  - DATA: 8 bits, LSB first, shifted into `shift_reg` on the `sub_cnt`=9 tick. After bit 7's `sub_cnt`=15 tick → STOP.
  - STOP: decided on the `sub_cnt`=9 tick. If the majority is 1: `data`<=`shift_reg` and pulse `rx_done`. If the majority is 0: pulse `frame_err` and leave `data` unchanged. Either way → IDLE immediately, so the remaining half stop bit is free for resync.
- **Re-arm after a low line:** after a frame error with the line still low, IDLE needs a new 1→0 edge, so a held-low (break) line produces exactly one `frame_err`.
- **Reset:** reset at any time, including mid-frame, returns to IDLE with all counters at 0. The partial byte is discarded.
- **Output reset values:** `data`=8'h00, `rx_done`=0, `frame_err`=0, `rx_busy`=0.

## Timing
- Synchroniser latency: 2 clocks from the pin to `rx_s`.
- `rx_done` and `frame_err` are registered and high for exactly 1 clock. They are never high together.
- Latency from the START entry cycle to the `rx_done` rising edge is (9*16+9)*bps_div + bps_div clocks, which is 4158 at the defaults.
- `data` is valid in the same cycle `rx_done` is high, and stays stable until the next `rx_done`.
- `rx_busy` rises the cycle after the edge is detected. It falls in the same cycle that `rx_done`/`frame_err` rises, or on a false-start abort.
- Tolerated baud mismatch: at least ±3% between transmitter and receiver, including the integer-division error (0.47% at the defaults).
- Back-to-back frames with no idle time between the stop bit and the next start bit must be received without loss.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state encoding (IDLE, START, DATA, STOP).
  - OVERSAMPLE=16 and the sample indices 7/8/9.
  - A `bps_div` calculation function, also used by `uart_byte_tx`.
- Sub-module `uart_baud_tick` contains the `div_cnt` divider with a synchronous clear input and the `tick` output, parameterised by `bps_div`. `uart_byte_rx` instantiates it once.

## Test plan
- **Reset:** hold `reset_n`=0 with `uart_rx`=1 → `data`=8'h00, `rx_done`=0, `frame_err`=0, `rx_busy`=0. No pulses for 10000 clocks after release.
- **Single byte:** send 0x55 at 115200 from a bench bit driver at 434 clk/bit → exactly one `rx_done`, `data`=0x55, `frame_err` stays 0, latency 4158±3 clocks from START entry.
- **Back-to-back and baud skew:** send 0xA3 then 0x0F with no gap, then 0xC6 at +3% and 0xC6 at -3% bit period → four `rx_done` pulses carrying 0xA3, 0x0F, 0xC6, 0xC6.
- **Glitch rejection:**
  - Drive a 100-clock low pulse on an idle line → `rx_busy` pulses, no `rx_done`, no `frame_err`. A following 0x3C is received correctly.
  - Invert a single clock at `sub_cnt`=8 of bit 2 → the byte is still received correctly.
- **Framing error:** after 0x3C, send 0xFF with the stop bit driven 0, then hold the line low for 5 bit times → exactly one `frame_err` pulse, no `rx_done`, `data` stays 0x3C. After the line returns high, 0x81 is received.
- **Reset mid-frame:** assert `reset_n` during bit 4 of 0x5A → all outputs return to reset values immediately. After release and line idle, 0x81 is received with `data`=0x81.
